rib_arb: RTL and testbench
==========================

RIB_ARB -- requirements
Module: rib_arb

Interface
REQ-001 SHALL have parameter NUM_M, 4, number of master ports (2..8).
REQ-002 SHALL have parameter NUM_S, 8, number of slave ports (1..16); slave index = addr[31:28].
REQ-003 SHALL have parameter AW, 32, address width; DW, 32, data width.
REQ-004 SHALL have parameter FETCH_IDX, 1, instruction-fetch master: excluded from hold, gets NOP when not granted.
REQ-005 SHALL have parameter TIMEOUT, 16, max BUSY cycles before forced completion (≥2).
REQ-006 SHALL have port clk  in  1  clock; single clock, all state on rising edge.
REQ-007 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-008 SHALL have m_addr_i in NUM_M*AW, m_data_i in NUM_M*DW, m_data_o out NUM_M*DW, flattened, master k at slice k.
REQ-009 SHALL have m_req_i in NUM_M, m_we_i in NUM_M, m_ready_o out NUM_M: per-master request, write, completion.
REQ-010 SHALL have s_addr_o out NUM_S*AW, s_data_o out NUM_S*DW, s_data_i in NUM_S*DW, flattened.
REQ-011 SHALL have s_we_o out NUM_S, s_req_o out NUM_S, s_ready_i in NUM_S: per-slave write, request, completion.
REQ-012 SHALL have hold_flag_o out 1 (pipeline hold) and err_o out 1 (one-cycle bus-error pulse).

Function
REQ-013 SHALL implement FSM IDLE/BUSY; in IDLE grant is computed combinationally from m_req_i and the arbitration policy (REQ-026/027).
REQ-014 SHALL route only the granted master's addr/data/we to slave sel=addr[31:28]; all other slave outputs and s_req_o SHALL be 0.
REQ-015 SHALL drive s_req_o[sel]=1 while granted master's req is 1; s_ready_i[sel]=1 completes in the same cycle (zero-wait slave).
REQ-016 On completion SHALL drive m_ready_o[grant]=1 and m_data_o[grant]=s_data_i[sel] for that cycle; non-granted masters get ready 0, data 0, except FETCH_IDX gets 0x00000013.
REQ-017 If in IDLE a granted request does not complete in-cycle, SHALL register grant, go BUSY next cycle; grant frozen until exit.
REQ-018 In BUSY, SHALL return to IDLE the cycle after completion; new arbitration only in IDLE.
REQ-019 In BUSY, if granted master drops req, SHALL abort: IDLE next cycle, no ready, no err, pointer unchanged.
REQ-020 In BUSY, counter SHALL count cycles; at TIMEOUT-1 without ready, SHALL force m_ready_o=1, m_data_o=0, err_o=1, then IDLE.
REQ-021 sel ≥ NUM_S SHALL complete same cycle with m_ready_o=1, data 0, err_o=1, no slave touched.
REQ-022 hold_flag_o SHALL be 1 iff any m_req_i[k]=1 for k≠FETCH_IDX, or FSM in BUSY.
REQ-023 Simultaneous completion and timeout in same cycle SHALL be treated as normal completion (err_o=0).

Reset
REQ-024 On rst low SHALL asynchronously set FSM=IDLE, grant register 0, rr pointer 0, counter 0.
REQ-025 During reset all m_ready_o, s_req_o, s_we_o, err_o SHALL be 0; reset mid-BUSY drops the transaction with no ready.

Configuration
REQ-026 With RIB_ARB_RR_EN defined: round-robin; search from pointer upward with wrap; pointer ← grant+1 (mod NUM_M) on completion (incl. error).
REQ-027 Without RIB_ARB_RR_EN: fixed priority, highest index wins; pointer logic absent.

Verification
REQ-028 Zero-wait: m0 read addr 0x1000_0004, s1 data 0xA5A5_A5A5 -> m_ready_o[0]=1, m_data_o[0]=0xA5A5_A5A5 same cycle, FSM stays IDLE.
REQ-029 Wait-state: m2 write to 0x3000_0000, s3 ready after 3 cycles -> s_req_o[3] 4 cycles, m_ready_o[2] in 4th, IDLE next; m0 request meanwhile waits.
REQ-030 Round-robin (RR_EN): m0..m3 request continuously, zero-wait slave -> grants 0,1,2,3,0; without macro -> grant 3 every cycle.
REQ-031 Timeout: TIMEOUT=16, s6 never ready -> m_ready_o=1, data 0, err_o pulse at 16th BUSY cycle, then IDLE.
REQ-032 Unmapped: NUM_S=8, addr 0x9000_0000 -> ready and err_o same cycle, all s_req_o=0.
REQ-033 Reset mid-BUSY: rst low in 2nd wait cycle -> outputs 0 immediately, IDLE, pointer 0 after release.

Source files
------------

// File: rtl/rib_arb.sv
// ============================================================================
//  Module      : rib_arb
//  Description : Bus arbiter / crossbar joining NUM_M masters to NUM_S
//                slaves. The slave is picked by the top address nibble. Two
//                states, IDLE and BUSY:
//                  - Zero-wait slaves complete in the cycle of the request.
//                  - Slow slaves keep the bus; grant is frozen while BUSY.
//                  - A BUSY transfer is aborted if its master drops req.
//                  - After TIMEOUT BUSY cycles the transfer is forced to end
//                    with a bus error.
//                Unmapped slave indices complete at once with a bus error.
//  Ports       : clk, rst (async, active low)
//                m_addr_i/m_data_i/m_data_o  flattened per-master buses
//                m_req_i/m_we_i/m_ready_o    per-master request/write/done
//                s_addr_o/s_data_o/s_data_i  flattened per-slave buses
//                s_we_o/s_req_o/s_ready_i    per-slave write/request/done
//                hold_flag_o                 pipeline hold
//                err_o                       one-cycle bus-error pulse
//  Config      : define RIB_ARB_RR_EN for round-robin arbitration;
//                otherwise fixed priority, highest master index wins.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rib_arb #(
    parameter int NUM_M     = 4,
    parameter int NUM_S     = 8,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int FETCH_IDX = 1,
    parameter int TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_M*AW-1:0] m_addr_i,
    input  logic [NUM_M*DW-1:0] m_data_i,
    output logic [NUM_M*DW-1:0] m_data_o,
    input  logic [NUM_M-1:0]    m_req_i,
    input  logic [NUM_M-1:0]    m_we_i,
    output logic [NUM_M-1:0]    m_ready_o,
    output logic [NUM_S*AW-1:0] s_addr_o,
    output logic [NUM_S*DW-1:0] s_data_o,
    input  logic [NUM_S*DW-1:0] s_data_i,
    output logic [NUM_S-1:0]    s_we_o,
    output logic [NUM_S-1:0]    s_req_o,
    input  logic [NUM_S-1:0]    s_ready_i,
    output logic                hold_flag_o,
    output logic                err_o
);

    localparam int               GW           = $clog2(NUM_M);
    localparam int               CW           = $clog2(TIMEOUT);
    localparam logic [DW-1:0]    C_NOP        = DW'(32'h0000_0013);
    localparam logic [NUM_M-1:0] C_FETCH_MASK = NUM_M'(1) << FETCH_IDX;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [GW-1:0] r_grant;
    logic [CW-1:0] r_cnt;

    logic [GW-1:0] w_arb;
    logic [GW-1:0] w_grant;
    logic          w_owner_vld;
    logic [3:0]    w_sel;
    logic          w_sel_map;
    logic          w_s_rdy;
    logic [DW-1:0] w_s_rd;
    logic          w_timeout;
    logic          w_done;
    logic          w_err;
    logic [AW-1:0] w_g_addr;

    logic [AW-1:0] w_m_addr [NUM_M];
    logic [DW-1:0] w_m_wdat [NUM_M];
    logic [DW-1:0] w_m_rdat [NUM_M];
    logic [DW-1:0] w_s_rdat [NUM_S];
    logic [AW-1:0] w_s_aout [NUM_S];
    logic [DW-1:0] w_s_wdat [NUM_S];

    // Unpack / repack the flattened buses into per-port arrays.
    generate
        for (genvar gk = 0; gk < NUM_M; gk++) begin : g_mst
            assign w_m_addr[gk]           = m_addr_i[gk*AW +: AW];
            assign w_m_wdat[gk]           = m_data_i[gk*DW +: DW];
            assign m_data_o[gk*DW +: DW]  = w_m_rdat[gk];
        end
        for (genvar gs = 0; gs < NUM_S; gs++) begin : g_slv
            assign w_s_rdat[gs]           = s_data_i[gs*DW +: DW];
            assign s_addr_o[gs*AW +: AW]  = w_s_aout[gs];
            assign s_data_o[gs*DW +: DW]  = w_s_wdat[gs];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbitration (only consulted in IDLE)
    // ------------------------------------------------------------------
`ifdef RIB_ARB_RR_EN
    logic [GW-1:0] r_ptr;

    // Search upward from the pointer, wrapping at NUM_M (which need not be
    // a power of two, hence the explicit wrap instead of natural overflow).
    always_comb begin : p_rr_pick
        logic [GW:0] v_sum;
        logic        v_found;
        w_arb   = r_ptr;
        v_found = 1'b0;
        v_sum   = '0;
        for (int i = 0; i < NUM_M; i++) begin
            v_sum = {1'b0, r_ptr} + (GW+1)'(i);
            if (v_sum >= (GW+1)'(NUM_M)) begin
                v_sum = v_sum - (GW+1)'(NUM_M);
            end
            if (!v_found && m_req_i[v_sum[GW-1:0]]) begin
                w_arb   = v_sum[GW-1:0];
                v_found = 1'b1;
            end
        end
    end

    // Pointer moves past the master that just finished, error or not;
    // an aborted transfer leaves it untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_done) begin
            r_ptr <= (w_grant == GW'(NUM_M-1)) ? '0 : w_grant + GW'(1);
        end
    end
`else
    // Fixed priority: later (higher) indices overwrite earlier ones.
    always_comb begin : p_fixed_pick
        w_arb = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (m_req_i[i]) begin
                w_arb = GW'(i);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Current owner and slave decode
    // ------------------------------------------------------------------
    assign w_grant     = (r_state == ST_BUSY) ? r_grant : w_arb;
    // In BUSY the owner is only valid while it keeps its request up; a
    // dropped request is the abort condition. Reset silences everything.
    assign w_owner_vld = rst && ((r_state == ST_IDLE) ? (|m_req_i) : m_req_i[r_grant]);
    assign w_g_addr    = w_m_addr[w_grant];
    assign w_sel       = w_g_addr[AW-1 -: 4];
    assign w_sel_map   = ({1'b0, w_sel} < 5'(NUM_S));

    always_comb begin : p_slave_lookup
        w_s_rdy = 1'b0;
        w_s_rd  = '0;
        for (int s = 0; s < NUM_S; s++) begin
            if (w_sel == 4'(s)) begin
                w_s_rdy = s_ready_i[s];
                w_s_rd  = w_s_rdat[s];
            end
        end
    end

    assign w_timeout = (r_state == ST_BUSY) && (r_cnt == CW'(TIMEOUT-1));
    // A slave ready in the timeout cycle wins: that is a normal completion.
    assign w_done    = w_owner_vld && (!w_sel_map || w_s_rdy || w_timeout);
    assign w_err     = w_owner_vld && (!w_sel_map || (!w_s_rdy && w_timeout));

    // ------------------------------------------------------------------
    // Master-side outputs
    // ------------------------------------------------------------------
    always_comb begin : p_master_out
        m_ready_o = '0;
        for (int k = 0; k < NUM_M; k++) begin
            w_m_rdat[k] = (k == FETCH_IDX) ? C_NOP : '0;
        end
        if (w_owner_vld) begin
            w_m_rdat[w_grant] = '0;
            if (w_done) begin
                m_ready_o[w_grant] = 1'b1;
                w_m_rdat[w_grant]  = (w_sel_map && w_s_rdy) ? w_s_rd : '0;
            end
        end
    end

    assign err_o       = w_err;
    assign hold_flag_o = (r_state == ST_BUSY) || (|(m_req_i & ~C_FETCH_MASK));

    // ------------------------------------------------------------------
    // Slave-side outputs: only the selected, mapped slave sees traffic.
    // ------------------------------------------------------------------
    always_comb begin : p_slave_out
        s_req_o = '0;
        s_we_o  = '0;
        for (int s = 0; s < NUM_S; s++) begin
            w_s_aout[s] = '0;
            w_s_wdat[s] = '0;
            if (w_owner_vld && w_sel_map && (w_sel == 4'(s))) begin
                s_req_o[s]  = 1'b1;
                s_we_o[s]   = m_we_i[w_grant];
                w_s_aout[s] = w_g_addr;
                w_s_wdat[s] = w_m_wdat[w_grant];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin : p_next_state
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_owner_vld && !w_done) w_state_nxt = ST_BUSY;
            ST_BUSY: if (!w_owner_vld || w_done) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) begin
                r_cnt <= '0;
                if (w_owner_vld && !w_done) begin
                    r_grant <= w_grant;
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rib_arb.sv
`default_nettype none

module tb_rib_arb;

    localparam int NUM_M     = 4;
    localparam int NUM_S     = 8;
    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int FETCH_IDX = 1;
    localparam int TIMEOUT   = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NUM_M*AW-1:0] m_addr_i;
    logic [NUM_M*DW-1:0] m_data_i;
    logic [NUM_M*DW-1:0] m_data_o;
    logic [NUM_M-1:0]    m_req_i;
    logic [NUM_M-1:0]    m_we_i;
    logic [NUM_M-1:0]    m_ready_o;
    logic [NUM_S*AW-1:0] s_addr_o;
    logic [NUM_S*DW-1:0] s_data_o;
    logic [NUM_S*DW-1:0] s_data_i;
    logic [NUM_S-1:0]    s_we_o;
    logic [NUM_S-1:0]    s_req_o;
    logic [NUM_S-1:0]    s_ready_i;
    logic                hold_flag_o;
    logic                err_o;

    rib_arb #(
        .NUM_M(NUM_M), .NUM_S(NUM_S), .AW(AW), .DW(DW),
        .FETCH_IDX(FETCH_IDX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_data_o(m_data_o),
        .m_req_i(m_req_i), .m_we_i(m_we_i), .m_ready_o(m_ready_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
        .s_we_o(s_we_o), .s_req_o(s_req_o), .s_ready_i(s_ready_i),
        .hold_flag_o(hold_flag_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------
    // Stimulus helpers (tasks assume entry at posedge+1)
    // ---------------------------------------------------------------
    task automatic idle_inputs();
        m_addr_i  = '0; m_data_i = '0; m_req_i = '0; m_we_i = '0;
        s_data_i  = '0; s_ready_i = '0;
    endtask

    task automatic set_m(input int k, input bit req, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_req_i[k] = req;
        m_we_i[k]  = we;
        m_addr_i[k*AW +: AW] = a;
        m_data_i[k*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] mdat(input int k);
        return m_data_o[k*DW +: DW];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
    endtask

    // ---------------------------------------------------------------
    // Transaction-level reference model
    // ---------------------------------------------------------------
    bit  md_busy;
    int  md_gnt, md_wait, md_ptr;
    bit  nx_busy;
    int  nx_gnt, nx_wait, nx_ptr;
    logic [NUM_M-1:0]    exp_m_ready;
    logic [NUM_M*DW-1:0] exp_m_data;
    logic                exp_err, exp_hold;
    logic [NUM_S-1:0]    exp_s_req, exp_s_we;
    logic [NUM_S*AW-1:0] exp_s_addr;
    logic [NUM_S*DW-1:0] exp_s_data;

    task automatic model_reset();
        md_busy = 0; md_gnt = 0; md_wait = 0; md_ptr = 0;
    endtask

    function automatic int model_pick();
`ifdef RIB_ARB_RR_EN
        for (int i = 0; i < NUM_M; i++) begin
            int k = (md_ptr + i) % NUM_M;
            if (m_req_i[k]) return k;
        end
`else
        for (int k = NUM_M - 1; k >= 0; k--) begin
            if (m_req_i[k]) return k;
        end
`endif
        return -1;
    endfunction

    task automatic model_eval();
        int owner, sel;
        bit done;
        exp_m_ready = '0; exp_m_data = '0; exp_err = 0;
        exp_s_req = '0; exp_s_we = '0; exp_s_addr = '0; exp_s_data = '0;
        exp_m_data[FETCH_IDX*DW +: DW] = 32'h13;
        nx_busy = 0; nx_gnt = md_gnt; nx_wait = 0; nx_ptr = md_ptr;
        done = 0;
        owner = -1;
        if (!md_busy) owner = model_pick();
        else if (m_req_i[md_gnt]) owner = md_gnt;
        if (owner >= 0) begin
            sel = int'(m_addr_i[owner*AW + 28 +: 4]);
            exp_m_data[owner*DW +: DW] = '0;
            if (sel >= NUM_S) begin
                done = 1; exp_err = 1;
            end else begin
                exp_s_req[sel] = 1'b1;
                exp_s_we[sel]  = m_we_i[owner];
                exp_s_addr[sel*AW +: AW] = m_addr_i[owner*AW +: AW];
                exp_s_data[sel*DW +: DW] = m_data_i[owner*DW +: DW];
                if (s_ready_i[sel]) begin
                    done = 1;
                    exp_m_data[owner*DW +: DW] = s_data_i[sel*DW +: DW];
                end else if (md_busy && md_wait == TIMEOUT - 1) begin
                    done = 1; exp_err = 1;
                end else begin
                    nx_busy = 1; nx_gnt = owner;
                    nx_wait = md_busy ? md_wait + 1 : 0;
                end
            end
            if (done) begin
                exp_m_ready[owner] = 1'b1;
                nx_ptr = (owner + 1) % NUM_M;
            end
        end
        exp_hold = md_busy || ((m_req_i & ~(NUM_M'(1) << FETCH_IDX)) != '0);
    endtask

    task automatic model_commit();
        md_busy = nx_busy; md_gnt = nx_gnt; md_wait = nx_wait; md_ptr = nx_ptr;
    endtask

    // ---------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        m_req_i   = 4'b1101;
        m_we_i    = 4'b1111;
        m_addr_i  = {32'h3000_0000, 32'h1000_0000, 32'h2000_0000, 32'h9000_0000};
        s_ready_i = '1;
        #2;
        n_cmp++; if (m_ready_o !== '0) begin n_err++; $display("FAIL rst_m_ready got %b want 0", m_ready_o); end
        n_cmp++; if (s_req_o   !== '0) begin n_err++; $display("FAIL rst_s_req got %b want 0", s_req_o); end
        n_cmp++; if (s_we_o    !== '0) begin n_err++; $display("FAIL rst_s_we got %b want 0", s_we_o); end
        n_cmp++; if (err_o     !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", err_o); end
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        n_cmp++; if (hold_flag_o !== 1'b0) begin n_err++; $display("FAIL rst_idle_hold got %b want 0", hold_flag_o); end
        next_cycle();
    endtask

    task automatic test_zero_wait();
        logic [DW-1:0] d;
        idle_inputs();
        s_ready_i = '1;
        for (int s = 0; s < NUM_S; s++) s_data_i[s*DW +: DW] = $urandom;
        s_data_i[1*DW +: DW] = 32'hA5A5_A5A5;
        set_m(0, 1, 0, 32'h1000_0004, $urandom);
        @(negedge clk);
        n_cmp++; if (m_ready_o !== 4'b0001) begin n_err++; $display("FAIL zw_ready got %b want 0001", m_ready_o); end
        n_cmp++; if (mdat(0) !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL zw_data got %h want a5a5a5a5", mdat(0)); end
        n_cmp++; if (s_req_o !== 8'h02) begin n_err++; $display("FAIL zw_s_req got %b want 00000010", s_req_o); end
        n_cmp++; if (s_addr_o[1*AW +: AW] !== 32'h1000_0004) begin n_err++; $display("FAIL zw_s_addr got %h want 10000004", s_addr_o[1*AW +: AW]); end
        n_cmp++; if (mdat(FETCH_IDX) !== 32'h13) begin n_err++; $display("FAIL zw_fetch_nop got %h want 00000013", mdat(FETCH_IDX)); end
        n_cmp++; if (hold_flag_o !== 1'b1) begin n_err++; $display("FAIL zw_hold got %b want 1", hold_flag_o); end
        next_cycle();
        // Next cycle: only the fetch master; FSM must still be IDLE.
        d = $urandom;
        s_data_i[1*DW +: DW] = d;
        set_m(0, 0, 0, '0, '0);
        set_m(FETCH_IDX, 1, 0, 32'h1000_0000, '0);
        @(negedge clk);
        n_cmp++; if (hold_flag_o !== 1'b0) begin n_err++; $display("FAIL zw_fetch_hold got %b want 0", hold_flag_o); end
        n_cmp++; if (m_ready_o !== 4'b0010) begin n_err++; $display("FAIL zw_fetch_ready got %b want 0010", m_ready_o); end
        n_cmp++; if (mdat(FETCH_IDX) !== d) begin n_err++; $display("FAIL zw_fetch_data got %h want %h", mdat(FETCH_IDX), d); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_wait_state();
        logic [DW-1:0] wd;
        wd = $urandom;
        idle_inputs();
        s_ready_i = 8'b1111_0111;
        set_m(2, 1, 1, 32'h3000_0000, wd);
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) set_m(0, 1, 0, 32'h1000_0000, '0);
            if (c == 4) s_ready_i[3] = 1'b1;
            @(negedge clk);
            n_cmp++; if (s_req_o !== 8'h08) begin n_err++; $display("FAIL ws_s_req c%0d got %b want 00001000", c, s_req_o); end
            n_cmp++; if (s_we_o !== 8'h08) begin n_err++; $display("FAIL ws_s_we c%0d got %b want 00001000", c, s_we_o); end
            n_cmp++; if (s_data_o[3*DW +: DW] !== wd) begin n_err++; $display("FAIL ws_s_data c%0d got %h want %h", c, s_data_o[3*DW +: DW], wd); end
            n_cmp++; if (m_ready_o !== ((c == 4) ? 4'b0100 : 4'b0000)) begin n_err++; $display("FAIL ws_ready c%0d got %b want %b", c, m_ready_o, (c == 4) ? 4'b0100 : 4'b0000); end
            next_cycle();
        end
        set_m(2, 0, 0, '0, '0);
        @(negedge clk);
        n_cmp++; if (m_ready_o !== 4'b0001) begin n_err++; $display("FAIL ws_m0_after got %b want 0001", m_ready_o); end
        n_cmp++; if (s_req_o !== 8'h02) begin n_err++; $display("FAIL ws_m0_s_req got %b want 00000010", s_req_o); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_arbitration();
        int exp_g [5];
`ifdef RIB_ARB_RR_EN
        exp_g = '{0, 1, 2, 3, 0};
`else
        exp_g = '{3, 3, 3, 3, 3};
`endif
        pulse_reset();
        s_ready_i = '1;
        for (int k = 0; k < NUM_M; k++) set_m(k, 1, 0, 32'h1000_0000 + 32'(k * 4), $urandom);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (m_ready_o !== (NUM_M'(1) << exp_g[c])) begin n_err++; $display("FAIL arb_grant c%0d got %b want master %0d", c, m_ready_o, exp_g[c]); end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        logic [DW-1:0] sd;
        for (int mode = 0; mode < 2; mode++) begin
            sd = $urandom;
            idle_inputs();
            s_ready_i = 8'hBF;
            s_data_i[6*DW +: DW] = sd;
            set_m(0, 1, 0, 32'h6000_0010, $urandom);
            @(negedge clk);
            n_cmp++; if (m_ready_o !== 4'b0000) begin n_err++; $display("FAIL to_idle_ready m%0d got %b want 0000", mode, m_ready_o); end
            next_cycle();
            for (int b = 1; b <= TIMEOUT; b++) begin
                if (b == TIMEOUT && mode == 1) s_ready_i[6] = 1'b1;
                @(negedge clk);
                if (b < TIMEOUT) begin
                    n_cmp++; if ({m_ready_o, err_o} !== 5'b0) begin n_err++; $display("FAIL to_wait m%0d b%0d got ready=%b err=%b want 0000/0", mode, b, m_ready_o, err_o); end
                end else begin
                    n_cmp++; if (m_ready_o !== 4'b0001) begin n_err++; $display("FAIL to_ready m%0d got %b want 0001", mode, m_ready_o); end
                    n_cmp++; if (err_o !== (mode == 0)) begin n_err++; $display("FAIL to_err m%0d got %b want %0d", mode, err_o, mode == 0); end
                    n_cmp++; if (mdat(0) !== ((mode == 0) ? 32'h0 : sd)) begin n_err++; $display("FAIL to_data m%0d got %h want %h", mode, mdat(0), (mode == 0) ? 32'h0 : sd); end
                end
                next_cycle();
            end
            set_m(0, 0, 0, '0, '0);
            @(negedge clk);
            n_cmp++; if ({hold_flag_o, err_o} !== 2'b00) begin n_err++; $display("FAIL to_after m%0d got hold=%b err=%b want 0/0", mode, hold_flag_o, err_o); end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_unmapped();
        idle_inputs();
        s_ready_i = 8'($urandom);
        set_m(3, 1, 1, 32'h9000_0000 | 32'($urandom_range(0, 255)), $urandom);
        @(negedge clk);
        n_cmp++; if (m_ready_o !== 4'b1000) begin n_err++; $display("FAIL um_ready got %b want 1000", m_ready_o); end
        n_cmp++; if (err_o !== 1'b1) begin n_err++; $display("FAIL um_err got %b want 1", err_o); end
        n_cmp++; if ({s_req_o, s_we_o} !== 16'h0) begin n_err++; $display("FAIL um_slaves got req=%b we=%b want 0/0", s_req_o, s_we_o); end
        n_cmp++; if (mdat(3) !== 32'h0) begin n_err++; $display("FAIL um_data got %h want 0", mdat(3)); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL um_pulse got %b want 0", err_o); end
        next_cycle();
    endtask

    task automatic test_abort();
        idle_inputs();
        set_m(2, 1, 0, 32'h3000_0000, '0);
        next_cycle();
        next_cycle();
        set_m(2, 0, 0, 32'h3000_0000, '0);
        @(negedge clk);
        n_cmp++; if ({m_ready_o, err_o, s_req_o} !== 13'h0) begin n_err++; $display("FAIL ab_out got ready=%b err=%b sreq=%b want 0", m_ready_o, err_o, s_req_o); end
        n_cmp++; if (hold_flag_o !== 1'b1) begin n_err++; $display("FAIL ab_hold_busy got %b want 1", hold_flag_o); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (hold_flag_o !== 1'b0) begin n_err++; $display("FAIL ab_idle got %b want 0", hold_flag_o); end
        next_cycle();
    endtask

    task automatic test_reset_busy();
        int first;
`ifdef RIB_ARB_RR_EN
        first = 0;
`else
        first = 3;
`endif
        idle_inputs();
        set_m(0, 1, 1, 32'h6000_0000, $urandom);
        next_cycle();
        next_cycle();
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if ({m_ready_o, s_req_o, s_we_o, err_o} !== 21'h0) begin n_err++; $display("FAIL rb_out got ready=%b sreq=%b swe=%b err=%b want 0", m_ready_o, s_req_o, s_we_o, err_o); end
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        n_cmp++; if (hold_flag_o !== 1'b0) begin n_err++; $display("FAIL rb_idle got %b want 0", hold_flag_o); end
        next_cycle();
        s_ready_i = '1;
        for (int k = 0; k < NUM_M; k++) set_m(k, 1, 0, 32'h1000_0000, $urandom);
        @(negedge clk);
        n_cmp++; if (m_ready_o !== (NUM_M'(1) << first)) begin n_err++; $display("FAIL rb_first got %b want master %0d", m_ready_o, first); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_random();
        bit on [NUM_M];
        pulse_reset();
        model_reset();
        for (int k = 0; k < NUM_M; k++) on[k] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NUM_M; k++) begin
                if (on[k]) begin
                    if ($urandom_range(0, 99) < 12) begin on[k] = 0; m_req_i[k] = 1'b0; end
                end else if ($urandom_range(0, 99) < 40) begin
                    on[k] = 1;
                    set_m(k, 1, 1'($urandom), {4'($urandom_range(0, 9)), 28'($urandom)}, '0);
                end
                m_data_i[k*DW +: DW] = $urandom;
            end
            for (int s = 0; s < NUM_S; s++) begin
                s_ready_i[s] = ($urandom_range(0, 99) < 30);
                s_data_i[s*DW +: DW] = $urandom;
            end
            @(negedge clk);
            model_eval();
            n_cmp++; if ({m_ready_o, err_o, hold_flag_o} !== {exp_m_ready, exp_err, exp_hold}) begin n_err++; $display("FAIL rnd_ctrl c%0d got ready=%b err=%b hold=%b want ready=%b err=%b hold=%b", c, m_ready_o, err_o, hold_flag_o, exp_m_ready, exp_err, exp_hold); end
            n_cmp++; if (m_data_o !== exp_m_data) begin n_err++; $display("FAIL rnd_mdata c%0d got %h want %h", c, m_data_o, exp_m_data); end
            n_cmp++; if ({s_req_o, s_we_o} !== {exp_s_req, exp_s_we}) begin n_err++; $display("FAIL rnd_sctrl c%0d got req=%b we=%b want req=%b we=%b", c, s_req_o, s_we_o, exp_s_req, exp_s_we); end
            n_cmp++; if ({s_addr_o, s_data_o} !== {exp_s_addr, exp_s_data}) begin n_err++; $display("FAIL rnd_sbus c%0d got %h %h want %h %h", c, s_addr_o, s_data_o, exp_s_addr, exp_s_data); end
            @(posedge clk);
            model_commit();
            #1;
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_zero_wait();
        test_wait_state();
        test_arbitration();
        test_timeout();
        test_unmapped();
        test_abort();
        test_reset_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
